// File: rtl/pocket_pkg.sv
// Shared types for the pocket event path: ball/hole ids and the queued event record.
package pocket_pkg;

  localparam int NUM_BALLS_MAX = 16;
  localparam int CUE_BALL      = 0;

  typedef logic [3:0] ball_id_t;
  typedef logic [2:0] hole_id_t;

  typedef struct packed {
    ball_id_t ball;
    hole_id_t hole;
  } pocket_event_t;

endpackage

// File: rtl/pocket_event_fifo.sv
// Small synchronous event queue; head is read straight from the storage registers
// so it holds steady until popped. Push is accepted when full if a pop frees a slot.
module pocket_event_fifo
  import pocket_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  pocket_event_t push_data,
  input  logic          pop,
  output pocket_event_t head,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  pocket_event_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop) && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // An empty queue presents a zero head so the outputs match their reset values.
  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/pocket_scheduler.sv
// Turns per-ball hole-overlap levels into a round-robin ordered stream of {ball, hole}
// events and tracks the game's pocketed mask, per-turn count and cue-ball foul.
module pocket_scheduler
  import pocket_pkg::*;
#(
  parameter int NUM_BALLS  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BALLS-1:0]   hitLevel,
  input  logic [NUM_BALLS*3-1:0] hitHole,
  input  logic                   turnStart,
  input  logic                   gameClear,
  input  logic                   evReady,
  output logic                   evValid,
  output logic [3:0]             evBall,
  output logic [2:0]             evHole,
  output logic [NUM_BALLS-1:0]   pocketedMask,
  output logic [4:0]             turnPocketCount,
  output logic                   cueFoul,
  output logic                   cueRespawn,
  output logic                   overflow
);

  localparam int PW = $clog2(NUM_BALLS);

  logic [NUM_BALLS-1:0] hit_lvl_p1;
  logic [NUM_BALLS-1:0] pending_p1;
  hole_id_t             pend_hole_p1 [NUM_BALLS];
  logic [NUM_BALLS-1:0] rise;
  logic [NUM_BALLS-1:0] ignore;
  logic [NUM_BALLS-1:0] accept;
  logic [NUM_BALLS-1:0] grant_oh;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        rr_next;
  logic [PW-1:0]        gnt_idx;
  logic                 gnt_found;
  logic                 grant;
  logic                 cue_gnt;
  logic                 obj_gnt;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  pocket_event_t        push_ev;
  pocket_event_t        head_ev;

  function automatic logic [4:0] sat_inc5(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

  // Stage p0 -> p1: edge detect and capture of newly pocketed balls.
  assign ignore = {pocketedMask[NUM_BALLS-1:1], 1'b0};
  assign rise   = hitLevel & ~hit_lvl_p1;
  assign accept = gameClear ? '0 : (rise & ~ignore);

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BALLS; i++) begin
      if (accept[i] && !pending_p1[i]) pend_hole_p1[i] <= hitHole[3*i +: 3];
    end
  end

  // Stage p1 -> queue: round-robin pick of the first pending ball at or after rr_ptr.
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NUM_BALLS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_BALLS) idx = idx - NUM_BALLS;
      if (!gnt_found && pending_p1[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'(idx);
      end
    end
  end

  assign grant    = gnt_found && !fifo_full && !gameClear;
  assign grant_oh = grant ? (NUM_BALLS'(1) << gnt_idx) : '0;
  assign cue_gnt  = grant && (gnt_idx == PW'(CUE_BALL));
  assign obj_gnt  = grant && (gnt_idx != PW'(CUE_BALL));
  assign rr_next  = (gnt_idx == PW'(NUM_BALLS - 1)) ? '0 : gnt_idx + 1'b1;
  assign push_ev  = '{ball: ball_id_t'(gnt_idx), hole: pend_hole_p1[gnt_idx]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_lvl_p1 <= '0;
      cueRespawn <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      hit_lvl_p1 <= hitLevel;
      cueRespawn <= cue_gnt;
      overflow   <= overflow | (|(accept & pending_p1));
    end
  end

  // A second rise on a still-pending ball is dropped, keeping the first hole.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_p1      <= '0;
      rr_ptr          <= '0;
      pocketedMask    <= '0;
      turnPocketCount <= '0;
      cueFoul         <= 1'b0;
    end else if (gameClear) begin
      pending_p1      <= '0;
      rr_ptr          <= '0;
      pocketedMask    <= '0;
      turnPocketCount <= '0;
      cueFoul         <= 1'b0;
    end else begin
      pending_p1   <= (pending_p1 & ~grant_oh) | (accept & ~pending_p1);
      pocketedMask <= pocketedMask | {grant_oh[NUM_BALLS-1:1], 1'b0};
      if (grant) rr_ptr <= rr_next;
      if (turnStart) begin
        turnPocketCount <= obj_gnt ? 5'd1 : 5'd0;
        cueFoul         <= cue_gnt;
      end else begin
        if (obj_gnt) turnPocketCount <= sat_inc5(turnPocketCount);
        if (cue_gnt) cueFoul <= 1'b1;
      end
    end
  end

  // Queue -> consumer: registered head with valid/ready handshake.
  assign fifo_pop = evValid && evReady;

  pocket_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (gameClear),
    .push      (grant),
    .push_data (push_ev),
    .pop       (fifo_pop),
    .head      (head_ev),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign evValid = !fifo_empty;
  assign evBall  = head_ev.ball;
  assign evHole  = head_ev.hole;

endmodule
